stepper_axis_array: RTL and testbench

Parametrised N-axis step/direction pulse generator that supersedes the fixed three-axis printer movement path. It sits between the printer controller (move commands, homing requests) and the Pmod driver pins. Each axis accepts a move of a given step count, direction and step period over a valid/ready handshake, honours a direction setup time, tracks its position, and supports a coordinated homing sequence against per-axis endstops. It also owns the driver-supply enables.

---
 rtl/stepper_pkg.sv | 17 +
 rtl/stepper_axis.sv | 148 ++++++++++++++
 rtl/stepper_axis_array.sv | 71 +++++++
 tb/tb_stepper_axis_array.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and defaults for the step/direction axis array.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, GAP, HOME_SETUP, HOME_PULSE, HOME_GAP
  } axis_state_t;

  localparam int PULSE_CYC_D = 40;
  localparam int DIR_SETUP_D = 80;
  localparam int HOME_PER_D  = 4000;

  // Rise-to-rise spacing never drops below one high plus one equal low phase.
  function automatic int eff_period(input int period, input int pulse_cyc);
    return (period < 2 * pulse_cyc) ? 2 * pulse_cyc : period;
  endfunction

endpackage

// File: rtl/stepper_axis.sv
// One step/dir axis: move/homing FSM, phase counter, endstop synchroniser, position.
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int POS_W     = 16,
  parameter int PER_W     = 16,
  parameter int PULSE_CYC = PULSE_CYC_D,
  parameter int DIR_SETUP = DIR_SETUP_D,
  parameter int HOME_PER  = HOME_PER_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             home_start,
  input  logic             cmd_dir,
  input  logic [POS_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             endstop,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic [POS_W-1:0] pos
);

  localparam int CNT_W = $clog2((HOME_PER > DIR_SETUP ? HOME_PER : DIR_SETUP) + (1 << PER_W));

  axis_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [POS_W-1:0] steps_q;
  logic [PER_W-1:0] per_q;
  logic             es_s1, es_s2;
  logic             ld, ld_home, rise, clr_pos, hit;

  assign busy = (state != IDLE);
  assign hit  = es_s2 & ~dir;

  always_comb begin
    state_n = state;
    cnt_n   = cnt - CNT_W'(1);
    ld      = 1'b0;
    ld_home = 1'b0;
    rise    = 1'b0;
    clr_pos = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = CNT_W'(DIR_SETUP - 1);
        if (home_start) begin
          state_n = HOME_SETUP;
          ld_home = 1'b1;
        end else if (start) begin
          state_n = SETUP;
          ld      = 1'b1;
        end
      end
      SETUP: begin
        if (steps_q == '0) state_n = IDLE;
        else if (hit) begin
          state_n = IDLE;
          clr_pos = 1'b1;
        end else if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
          rise    = 1'b1;
        end
      end
      // A limit hit lets the running pulse finish before aborting.
      PULSE: if (cnt == '0) begin
        if (hit) begin
          state_n = IDLE;
          clr_pos = 1'b1;
        end else if (steps_q == '0) state_n = IDLE;
        else begin
          state_n = GAP;
          cnt_n   = CNT_W'(eff_period(int'(per_q), PULSE_CYC) - PULSE_CYC - 1);
        end
      end
      GAP: begin
        if (hit) begin
          state_n = IDLE;
          clr_pos = 1'b1;
        end else if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
          rise    = 1'b1;
        end
      end
      HOME_SETUP: if (cnt == '0) begin
        if (es_s2) begin
          state_n = IDLE;
          clr_pos = 1'b1;
        end else begin
          state_n = HOME_PULSE;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
          rise    = 1'b1;
        end
      end
      HOME_PULSE: if (cnt == '0) begin
        if (es_s2) begin
          state_n = IDLE;
          clr_pos = 1'b1;
        end else begin
          state_n = HOME_GAP;
          cnt_n   = CNT_W'(HOME_PER - PULSE_CYC - 1);
        end
      end
      HOME_GAP: begin
        if (es_s2) begin
          state_n = IDLE;
          clr_pos = 1'b1;
        end else if (cnt == '0) begin
          state_n = HOME_PULSE;
          cnt_n   = CNT_W'(PULSE_CYC - 1);
          rise    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      steps_q <= '0;
      per_q   <= '0;
      dir     <= 1'b0;
      pos     <= '0;
      step    <= 1'b0;
      es_s1   <= 1'b0;
      es_s2   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      step  <= (state_n == PULSE) || (state_n == HOME_PULSE);
      es_s1 <= endstop;
      es_s2 <= es_s1;
      if (ld) begin
        steps_q <= cmd_steps;
        per_q   <= cmd_period;
        dir     <= cmd_dir;
      end else if (ld_home) dir <= 1'b0;
      else if (rise && (state == SETUP || state == GAP)) steps_q <= steps_q - POS_W'(1);
      if (clr_pos) pos <= '0;
      else if (rise) pos <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
    end
  end

endmodule

// File: rtl/stepper_axis_array.sv
// N-axis step/dir generator: per-axis engines plus homing coordination and supply enables.
module stepper_axis_array
  import stepper_pkg::*;
#(
  parameter int N_AXES    = 3,
  parameter int POS_W     = 16,
  parameter int PER_W     = 16,
  parameter int PULSE_CYC = PULSE_CYC_D,
  parameter int DIR_SETUP = DIR_SETUP_D,
  parameter int HOME_PER  = HOME_PER_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_AXES-1:0]            cmd_valid,
  output logic [N_AXES-1:0]            cmd_ready,
  input  logic [N_AXES-1:0]            cmd_dir,
  input  logic [N_AXES-1:0][POS_W-1:0] cmd_steps,
  input  logic [N_AXES-1:0][PER_W-1:0] cmd_period,
  input  logic                         home_req,
  output logic                         home_done,
  input  logic [N_AXES-1:0]            endstop,
  output logic [N_AXES-1:0]            step,
  output logic [N_AXES-1:0]            dir,
  output logic [N_AXES-1:0]            sup,
  output logic [N_AXES-1:0]            busy,
  output logic [N_AXES-1:0][POS_W-1:0] pos
);

  logic homing, home_go;

  // sup doubles as the "out of reset" qualifier for accepting any request.
  assign home_go   = home_req & sup[0] & ~(|busy) & ~homing;
  assign cmd_ready = ~busy & sup & {N_AXES{~home_go & ~homing}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sup       <= '0;
      homing    <= 1'b0;
      home_done <= 1'b0;
    end else begin
      sup       <= '1;
      home_done <= 1'b0;
      if (home_go) homing <= 1'b1;
      else if (homing && !(|busy)) begin
        homing    <= 1'b0;
        home_done <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    stepper_axis #(
      .POS_W(POS_W), .PER_W(PER_W), .PULSE_CYC(PULSE_CYC),
      .DIR_SETUP(DIR_SETUP), .HOME_PER(HOME_PER)
    ) u_axis (
      .clk        (clk),
      .rst        (rst),
      .start      (cmd_valid[i] & cmd_ready[i]),
      .home_start (home_go),
      .cmd_dir    (cmd_dir[i]),
      .cmd_steps  (cmd_steps[i]),
      .cmd_period (cmd_period[i]),
      .endstop    (endstop[i]),
      .step       (step[i]),
      .dir        (dir[i]),
      .busy       (busy[i]),
      .pos        (pos[i])
    );
  end

endmodule

// File: tb/tb_stepper_axis_array.sv
// Directed bench: table of moves with hand-computed timing, plus limit, homing and reset sequences.
module tb_stepper_axis_array;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       cmd_valid, cmd_ready, cmd_dir, endstop, step, dir, sup, busy;
  logic [2:0][15:0] cmd_steps, cmd_period, pos;
  logic             home_req, home_done;

  int nvec = 0;
  int nfail = 0;

  stepper_axis_array dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .home_req(home_req), .home_done(home_done), .endstop(endstop),
    .step(step), .dir(dir), .sup(sup), .busy(busy), .pos(pos)
  );

  always #12 clk = ~clk;

  typedef struct {
    int ax, d, steps, per;      // command
    int es;                     // raise endstop 50 cycles after this rise (0 = never)
    int rises, first, sp, fall; // offsets counted from the handshake edge
    int p;                      // position afterwards
  } vec_t;

  vec_t vt[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_move(input vec_t v);
    int n, rises, last, hi, fall;
    logic prev;
    cmd_dir[v.ax]    = v.d[0];
    cmd_steps[v.ax]  = 16'(v.steps);
    cmd_period[v.ax] = 16'(v.per);
    cmd_valid[v.ax]  = 1'b1;
    tick;
    cmd_valid = '0;
    chk("dir_t1", int'(dir[v.ax]), v.d);
    chk("busy_t1", int'(busy[v.ax]), 1);
    n = 1; rises = 0; last = 0; hi = 0; fall = 0; prev = 1'b0;
    while (fall == 0 && n < 5000) begin
      if (step[v.ax] && !prev) begin
        rises++;
        if (rises == 1) chk("first_rise", n, v.first);
        else chk("rise_spacing", n - last, v.sp);
        last = n;
      end
      if (v.es != 0 && rises == v.es && n == last + 50) endstop[v.ax] = 1'b1;
      prev = step[v.ax];
      if (step[v.ax]) hi++;
      if (!busy[v.ax]) begin
        fall = n;
        chk("ready_at_fall", int'(cmd_ready[v.ax]), 1);
      end else begin
        tick;
        n++;
      end
    end
    chk("busy_fall", fall, v.fall);
    chk("rises", rises, v.rises);
    chk("high_cycles", hi, 40 * v.rises);
    chk("pos", int'(pos[v.ax]), v.p);
  endtask

  initial begin
    int n, seen, f0, idle_n, done_n, dcount, last1;
    int r[3];
    logic [2:0] prev;

    rst = 1'b1; cmd_valid = '0; cmd_dir = '0; cmd_steps = '0; cmd_period = '0;
    home_req = 1'b0; endstop = '0;

    //            ax d steps per  es rises first sp  fall  pos
    vt[0] = '{0, 1, 5,   200, 0, 5, 81, 200, 921, 5};
    vt[1] = '{1, 1, 3,   10,  0, 3, 81, 80,  281, 3};
    vt[2] = '{1, 0, 0,   100, 0, 0, 0,  0,   2,   3};
    vt[3] = '{2, 0, 2,   100, 0, 2, 81, 100, 221, 'hFFFE};
    vt[4] = '{2, 1, 2,   81,  0, 2, 81, 81,  202, 0};
    vt[5] = '{0, 0, 1,   80,  0, 1, 81, 0,   121, 4};
    vt[6] = '{2, 0, 100, 200, 3, 3, 81, 200, 534, 0};

    tick; tick;
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_sup", int'(sup), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_home_done", int'(home_done), 0);
    for (int a = 0; a < 3; a++) chk("rst_pos", int'(pos[a]), 0);
    rst = 1'b0;
    tick;
    chk("sup_after_rst", int'(sup), 7);
    chk("ready_after_rst", int'(cmd_ready), 7);

    for (int i = 0; i < 7; i++) run_move(vt[i]);

    // home_req while an axis is moving is dropped
    cmd_dir[1] = 1'b1; cmd_steps[1] = 16'd2; cmd_period[1] = 16'd100; cmd_valid[1] = 1'b1;
    tick;
    cmd_valid = '0;
    for (int i = 0; i < 5; i++) tick;
    home_req = 1'b1;
    tick;
    home_req = 1'b0;
    seen = 0; n = 0;
    while (busy[1] && n < 2000) begin
      if (busy[0] || busy[2] || home_done) seen = 1;
      tick;
      n++;
    end
    chk("home_ignored", seen, 0);
    chk("busy1_done", int'(busy[1]), 0);
    chk("pos1_after", int'(pos[1]), 5);

    // accepted homing: axis 0 and 2 already on endstops, axis 1 needs 4 pulses
    endstop[0] = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    home_req = 1'b1;
    cmd_valid[2] = 1'b1; cmd_dir[2] = 1'b1; cmd_steps[2] = 16'd5;
    #1;
    chk("ready_vs_home", int'(cmd_ready[2]), 0);
    tick;
    home_req = 1'b0;
    cmd_valid = '0;
    chk("home_dir", int'(dir), 0);
    chk("home_busy", int'(busy), 7);
    r = '{0, 0, 0}; prev = '0; f0 = 0; idle_n = 0; done_n = 0; dcount = 0; last1 = 0;
    n = 1;
    while (n < 20000 && !(done_n != 0 && n > done_n + 2)) begin
      for (int a = 0; a < 3; a++)
        if (step[a] && !prev[a]) begin
          r[a]++;
          if (a == 1) last1 = n;
        end
      prev = step;
      if (r[1] == 4 && n == last1 + 5) endstop[1] = 1'b1;
      if (n == 100) chk("ready_while_homing", int'(cmd_ready[0]), 0);
      if (!busy[0] && f0 == 0) f0 = n;
      if (busy == '0 && idle_n == 0) idle_n = n;
      if (home_done) begin
        dcount++;
        if (done_n == 0) done_n = n;
      end
      tick;
      n++;
    end
    chk("home_rises0", r[0], 0);
    chk("home_rises1", r[1], 4);
    chk("home_rises2", r[2], 0);
    chk("home_ax0_idle", f0, 81);
    chk("home_all_idle", idle_n, 12121);
    chk("home_done_count", dcount, 1);
    chk("home_done_at", done_n, idle_n + 1);
    for (int a = 0; a < 3; a++) chk("home_pos", int'(pos[a]), 0);

    // reset in the middle of a pulse
    endstop = '0;
    cmd_dir[0] = 1'b1; cmd_steps[0] = 16'd3; cmd_period[0] = 16'd200; cmd_valid[0] = 1'b1;
    tick;
    cmd_valid = '0;
    n = 0;
    while (!step[0] && n < 500) begin
      tick;
      n++;
    end
    chk("pre_rst_step", int'(step[0]), 1);
    chk("pre_rst_pos", int'(pos[0]), 1);
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1;
    tick;
    chk("midrst_step", int'(step), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_sup", int'(sup), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    chk("midrst_dir", int'(dir), 0);
    for (int a = 0; a < 3; a++) chk("midrst_pos", int'(pos[a]), 0);
    rst = 1'b0;
    tick;
    chk("post_rst_sup", int'(sup), 7);
    chk("post_rst_ready", int'(cmd_ready), 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
